// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer for a bank of JK flip-flops.
// One command at a time drives a masked J/K pattern for a requested number of
// clock edges, returns J/K to hold, then snapshots the bank Q and pulses done.
module jk_bank_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [N-1:0]     cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  input  logic [N-1:0]     q,
  output logic [N-1:0]     j,
  output logic [N-1:0]     k,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [N-1:0]     q_snap
);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSettle,
    StDone
  } state_e;

  state_e           state;
  // Edges still to apply after the current one; 0 means this cycle is the last.
  logic [CNT_W-1:0] rem;

  // Handshake status is a pure decode of the state register.
  assign cmd_ready = (state == StIdle);
  assign busy      = (state != StIdle);

  // Sequencer: all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      j       <= '0;
      k       <= '0;
      rem     <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
      q_snap  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_count != '0) begin
              j     <= cmd_mask & {N{cmd_op[1]}};
              k     <= cmd_mask & {N{cmd_op[0]}};
              rem   <= cmd_count - CNT_W'(1);
              state <= StApply;
            end else begin
              // Zero-length command is a pure snapshot request.
              j       <= '0;
              k       <= '0;
              aborted <= 1'b0;
              state   <= StSettle;
            end
          end
        end
        StApply: begin
          if (rem == '0) begin
            // Final edge: an abort here still counts as normal completion.
            j       <= '0;
            k       <= '0;
            aborted <= 1'b0;
            state   <= StSettle;
          end else if (abort) begin
            // The bank already sampled J/K at this edge, so it counts as applied.
            j       <= '0;
            k       <= '0;
            aborted <= 1'b1;
            state   <= StSettle;
          end else begin
            rem <= rem - CNT_W'(1);
          end
        end
        StSettle: begin
          q_snap <= q;
          done   <= 1'b1;
          state  <= StDone;
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl: directed plus randomized checks of jk_bank_ctrl against a
// command-level reference model; the JK bank itself is modelled behaviourally.
module tb_jk_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_count;
  logic       abort;
  logic [3:0] q;
  logic [3:0] j;
  logic [3:0] k;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] q_snap;

  int total = 0;
  int bad   = 0;

  // Expected bank contents after each completed command.
  logic [3:0] qm = 'x;

  jk_bank_ctrl #(.N(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .abort     (abort),
    .q         (q),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .q_snap    (q_snap)
  );

  always #5 clk = ~clk;

  // Four JK flip-flops, not reset, starting at X.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      case ({j[b], k[b]})
        2'b01:   q[b] <= 1'b0;
        2'b10:   q[b] <= 1'b1;
        2'b11:   q[b] <= ~q[b];
        default: q[b] <= q[b];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // Effect of applying one op for n edges to the masked bits.
  function automatic logic [3:0] model_apply(input logic [3:0] qi, input logic [1:0] op,
                                             input logic [3:0] mask, input int n);
    logic [3:0] r;
    r = qi;
    for (int b = 0; b < 4; b++) begin
      if (mask[b] && n > 0) begin
        case (op)
          2'b01:   r[b] = 1'b0;
          2'b10:   r[b] = 1'b1;
          2'b11:   r[b] = (n % 2 == 1) ? ~qi[b] : qi[b];
          default: r[b] = qi[b];
        endcase
      end
    end
    return r;
  endfunction

  // Issue one command and check every cycle until the controller is back in idle.
  // abort_at = i raises abort during the i-th cycle after accept (0 = never).
  // hold_valid keeps cmd_valid high with junk fields while busy; the caller must
  // then issue another command immediately.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] mask, input int cnt,
                         input int abort_at, input bit hold_valid);
    int         n;
    logic       exp_ab;
    logic [3:0] pj;
    logic [3:0] pk;
    int         guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_cmd", 4'(cmd_ready), 4'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = 8'(cnt);
    if (abort_at > 0 && abort_at < cnt) begin
      n      = abort_at;
      exp_ab = 1'b1;
    end else begin
      n      = cnt;
      exp_ab = 1'b0;
    end
    pj = (n > 0) ? (mask & {4{op[1]}}) : 4'b0;
    pk = (n > 0) ? (mask & {4{op[0]}}) : 4'b0;
    qm = model_apply(qm, op, mask, n);
    @(posedge clk);
    #1;
    for (int i = 1; i <= n + 3; i++) begin
      abort     = (i == abort_at) ? 1'b1 : ((i > n) ? 1'($urandom_range(0, 1)) : 1'b0);
      cmd_valid = hold_valid;
      cmd_op    = 2'($urandom);
      cmd_mask  = 4'($urandom);
      cmd_count = 8'($urandom_range(1, 255));
      @(negedge clk);
      if (i <= n) begin
        chk("apply_j", j, pj);
        chk("apply_k", k, pk);
        chk("apply_busy", 4'(busy), 4'd1);
        chk("apply_ready", 4'(cmd_ready), 4'd0);
        chk("apply_done", 4'(done), 4'd0);
      end else if (i == n + 1) begin
        chk("settle_j", j, 4'd0);
        chk("settle_k", k, 4'd0);
        chk("settle_busy", 4'(busy), 4'd1);
        chk("settle_done", 4'(done), 4'd0);
      end else if (i == n + 2) begin
        chk("done_pulse", 4'(done), 4'd1);
        chk("done_busy", 4'(busy), 4'd1);
        chk("done_ready", 4'(cmd_ready), 4'd0);
        chk("done_q_snap", q_snap, qm);
        chk("done_aborted", 4'(aborted), 4'(exp_ab));
        chk("done_jk", j | k, 4'd0);
      end else begin
        chk("idle_done", 4'(done), 4'd0);
        chk("idle_ready", 4'(cmd_ready), 4'd1);
        chk("idle_busy", 4'(busy), 4'd0);
        chk("idle_q_snap", q_snap, qm);
        chk("idle_aborted", 4'(aborted), 4'(exp_ab));
      end
      if (i < n + 3) begin
        @(posedge clk);
        #1;
      end
    end
    abort = 1'b0;
  endtask

  initial begin
    logic [3:0] q_before;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_mask  = 4'hf;
    cmd_count = 8'd5;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_j", j, 4'd0);
    chk("rst_k", k, 4'd0);
    chk("rst_busy", 4'(busy), 4'd0);
    chk("rst_done", 4'(done), 4'd0);
    chk("rst_aborted", 4'(aborted), 4'd0);
    chk("rst_q_snap", q_snap, 4'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 4'(cmd_ready), 4'd1);

    // Initialise the bank, then set / toggle / snapshot-only.
    run_cmd(2'b01, 4'b1111, 1, 0, 1'b0);
    run_cmd(2'b10, 4'b1010, 1, 0, 1'b0);
    chk("seq_q_1010", q_snap, 4'b1010);
    run_cmd(2'b11, 4'b0110, 3, 0, 1'b0);
    chk("seq_q_1100", q_snap, 4'b1100);
    run_cmd(2'b11, 4'b1111, 0, 0, 1'b0);
    chk("snap_only_q", q_snap, 4'b1100);

    // Abort mid-command, then abort on the final edge.
    run_cmd(2'b11, 4'b0001, 10, 3, 1'b0);
    chk("abort3_q", q_snap, 4'b1101);
    run_cmd(2'b11, 4'b0001, 10, 10, 1'b0);
    chk("abort10_q", q_snap, 4'b1101);

    // Asynchronous reset in the 5th APPLY cycle, away from any clock edge.
    q_before  = qm;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_mask  = 4'b1111;
    cmd_count = 8'd20;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_j", j, 4'd0);
    chk("arst_k", k, 4'd0);
    chk("arst_busy", 4'(busy), 4'd0);
    chk("arst_done", 4'(done), 4'd0);
    chk("arst_q_snap", q_snap, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_ready", 4'(cmd_ready), 4'd1);
    // Four toggle edges were applied before reset, so the bank is unchanged.
    chk("arst_bank_q", q, q_before);

    // Held cmd_valid with junk fields while busy; back-to-back accepts.
    run_cmd(2'b10, 4'b0100, 4, 0, 1'b1);
    run_cmd(2'b01, 4'b1000, 2, 0, 1'b1);
    run_cmd(2'b11, 4'b0001, 255, 0, 1'b0);
    chk("long_q", q_snap, qm);

    for (int t = 0; t < 25; t++) begin
      int cnt;
      int ab;
      cnt = $urandom_range(0, 12);
      ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, cnt + 2) : 0;
      run_cmd(2'($urandom), 4'($urandom), cnt, ab, 1'($urandom_range(0, 1)));
    end
    run_cmd(2'b00, 4'b1111, 2, 0, 1'b0);
    chk("final_q", q, qm);
    cmd_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
